// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic light monitor: phase encoding, error flag
// bit positions, default phase lengths and the legal phase successor.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    PhSync   = 2'd0,
    PhRed    = 2'd1,
    PhGreen  = 2'd2,
    PhYellow = 2'd3
  } phase_e;

  localparam int unsigned ErrOnehot = 0;
  localparam int unsigned ErrOrder  = 1;
  localparam int unsigned ErrTiming = 2;
  localparam int unsigned ErrStall  = 3;

  localparam int unsigned DefRedCycles    = 32;
  localparam int unsigned DefGreenCycles  = 20;
  localparam int unsigned DefYellowCycles = 7;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PhRed:    return PhGreen;
      PhGreen:  return PhYellow;
      PhYellow: return PhRed;
      default:  return PhSync;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_monitor.sv
// Passive protocol checker for traffic light outputs: one-hot, phase order, dwell and stall.
// Define TRAFFIC_LIGHT_MON_WATCHDOG_EN to flag overstays as soon as a phase outlives its length.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int unsigned RED_CYCLES    = DefRedCycles,
  parameter int unsigned GREEN_CYCLES  = DefGreenCycles,
  parameter int unsigned YELLOW_CYCLES = DefYellowCycles,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned CYC_W         = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  output logic             locked,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic [CYC_W-1:0] cycles,
  output logic             error,
  output logic [3:0]       err_flags
);

  localparam logic [CNT_W-1:0] RedLen    = CNT_W'(RED_CYCLES);
  localparam logic [CNT_W-1:0] GreenLen  = CNT_W'(GREEN_CYCLES);
  localparam logic [CNT_W-1:0] YellowLen = CNT_W'(YELLOW_CYCLES);

  phase_e           phase_q;
  logic             locked_q;
  logic [CNT_W-1:0] dwell_q;
  logic [CYC_W-1:0] cycles_q;
  logic             error_q;
  logic [3:0]       flags_q;
  logic             partial_q;
  logic             wd_fired_q;
  logic [2:0]       prev_q;
  logic             prev_vld_q;

  logic [2:0]       lights;
  logic             onehot;
  phase_e           obs;
  logic [CNT_W-1:0] phase_len;
  logic [3:0]       viol;

  assign lights = {red, yellow, green};
  assign onehot = $onehot(lights);

  always_comb begin
    if (red)        obs = PhRed;
    else if (green) obs = PhGreen;
    else            obs = PhYellow;
  end

  always_comb begin
    case (phase_q)
      PhRed:    phase_len = RedLen;
      PhGreen:  phase_len = GreenLen;
      PhYellow: phase_len = YellowLen;
      default:  phase_len = '0;
    endcase
  end

  always_comb begin
    viol = '0;
    // Stall is judged against the previous sample, independently of the phase checks.
    viol[ErrStall] = prev_vld_q && !enable && (lights != prev_q);
    if (!onehot) begin
      viol[ErrOnehot] = 1'b1;
    end else if (phase_q != PhSync) begin
      if (obs == phase_q) begin
`ifdef TRAFFIC_LIGHT_MON_WATCHDOG_EN
        if (!partial_q && !wd_fired_q && enable && (dwell_q >= phase_len)) begin
          viol[ErrTiming] = 1'b1;
        end
`endif
      end else if (obs == next_phase(phase_q)) begin
        if (!partial_q && !wd_fired_q && (dwell_q != phase_len)) begin
          viol[ErrTiming] = 1'b1;
        end
      end else begin
        viol[ErrOrder] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_q    <= PhSync;
      locked_q   <= 1'b0;
      dwell_q    <= '0;
      cycles_q   <= '0;
      error_q    <= 1'b0;
      flags_q    <= '0;
      partial_q  <= 1'b1;
      wd_fired_q <= 1'b0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      prev_q     <= lights;
      prev_vld_q <= 1'b1;
      error_q    <= |viol;
      flags_q    <= flags_q | viol;
      if (!onehot || viol[ErrOrder]) begin
        phase_q  <= PhSync;
        locked_q <= 1'b0;
        dwell_q  <= '0;
      end else if (phase_q == PhSync) begin
        if (obs == PhRed) begin
          phase_q    <= PhRed;
          locked_q   <= 1'b1;
          dwell_q    <= CNT_W'(enable);
          partial_q  <= 1'b1;
          wd_fired_q <= 1'b0;
        end
      end else if (obs == phase_q) begin
        if (enable && (dwell_q != '1)) begin
          dwell_q <= dwell_q + 1'b1;
        end
        if (viol[ErrTiming]) begin
          wd_fired_q <= 1'b1;
        end
      end else begin
        // Legal successor: the only remaining case once order violations are excluded.
        phase_q    <= obs;
        dwell_q    <= CNT_W'(enable);
        partial_q  <= 1'b0;
        wd_fired_q <= 1'b0;
        if ((phase_q == PhYellow) && (cycles_q != '1)) begin
          cycles_q <= cycles_q + 1'b1;
        end
      end
    end
  end

  assign locked    = locked_q;
  assign phase     = phase_q;
  assign dwell     = dwell_q;
  assign cycles    = cycles_q;
  assign error     = error_q;
  assign err_flags = flags_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios plus random light sequences
// checked every cycle against a rule-level model.
module tb_traffic_light_monitor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        red = 1'b0, yellow = 1'b0, green = 1'b0;
  logic        locked;
  logic [1:0]  phase;
  logic [7:0]  dwell;
  logic [15:0] cycles;
  logic        error;
  logic [3:0]  err_flags;

  int tests = 0;
  int fails = 0;
  int err_pulses = 0;

  traffic_light_monitor dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .red      (red),
    .yellow   (yellow),
    .green    (green),
    .locked   (locked),
    .phase    (phase),
    .dwell    (dwell),
    .cycles   (cycles),
    .error    (error),
    .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phases as 1=red 2=green 3=yellow, 0 = unsynchronised.
  int         m_phase, m_dwell, m_cycles;
  bit         m_locked, m_err, m_partial, m_wd, m_prev_ok, m_valid;
  logic [3:0] m_flags;
  logic [2:0] m_prev;

  function automatic int plen(input int p);
    case (p)
      1: return 32;
      2: return 20;
      3: return 7;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [3:0] f;
    int c, nxt;
    if (!reset_n) begin
      m_phase = 0; m_dwell = 0; m_cycles = 0; m_locked = 0; m_err = 0; m_flags = 0;
      m_partial = 1; m_wd = 0; m_prev_ok = 0; m_valid = 1;
    end else begin
      f = 0;
      c = red ? 1 : (green ? 2 : 3);
      nxt = (m_phase == 3) ? 1 : m_phase + 1;
      if (m_prev_ok && !enable && ({red, yellow, green} != m_prev)) f[3] = 1;
      if ((int'(red) + int'(yellow) + int'(green)) != 1) begin
        f[0] = 1; m_phase = 0; m_locked = 0; m_dwell = 0;
      end else if (m_phase == 0) begin
        if (c == 1) begin
          m_phase = 1; m_locked = 1; m_dwell = int'(enable); m_partial = 1; m_wd = 0;
        end
      end else if (c == m_phase) begin
        if (enable) begin
`ifdef TRAFFIC_LIGHT_MON_WATCHDOG_EN
          if (!m_partial && !m_wd && m_dwell + 1 > plen(m_phase)) begin
            f[2] = 1; m_wd = 1;
          end
`endif
          if (m_dwell < 255) m_dwell++;
        end
      end else if (c == nxt) begin
        if (!m_partial && !m_wd && m_dwell != plen(m_phase)) f[2] = 1;
        if (m_phase == 3 && m_cycles < 65535) m_cycles++;
        m_phase = c; m_dwell = int'(enable); m_partial = 0; m_wd = 0;
      end else begin
        f[1] = 1; m_phase = 0; m_locked = 0; m_dwell = 0;
      end
      m_flags = m_flags | f;
      m_err = (f != 0);
      m_prev = {red, yellow, green};
      m_prev_ok = 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("locked", 32'(locked), 32'(m_locked));
      check("phase", 32'(phase), 32'(m_phase));
      check("dwell", 32'(dwell), 32'(m_dwell));
      check("cycles", 32'(cycles), 32'(m_cycles));
      check("error", 32'(error), 32'(m_err));
      check("err_flags", 32'(err_flags), 32'(m_flags));
    end
  end

  task automatic cyc(input logic [2:0] ryg, input logic en, input logic rst_n, input int n);
    for (int i = 0; i < n; i++) begin
      {red, yellow, green} = ryg;
      enable = en;
      reset_n = rst_n;
      @(posedge clk);
      #1;
      if (error) err_pulses++;
    end
  endtask

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

  task automatic do_reset();
    cyc(R, 1'b1, 1'b0, 2);
  endtask

  function automatic logic [2:0] bits_of(input int p);
    return (p == 1) ? R : ((p == 2) ? G : Y);
  endfunction

  int snap;
  int cur, left, r, jit;
  logic en_r;

  initial begin
    // Reset state
    do_reset();
    check("rst_locked", 32'(locked), 0);
    check("rst_phase", 32'(phase), 0);
    check("rst_cycles", 32'(cycles), 0);
    check("rst_flags", 32'(err_flags), 0);

    // Clean sequence
    cyc(R, 1, 1, 40); cyc(G, 1, 1, 20); cyc(Y, 1, 1, 7);
    cyc(R, 1, 1, 32); cyc(G, 1, 1, 20); cyc(Y, 1, 1, 7); cyc(R, 1, 1, 1);
    check("clean_locked", 32'(locked), 1);
    check("clean_flags", 32'(err_flags), 0);
    check("clean_cycles", 32'(cycles), 2);
    check("clean_phase", 32'(phase), 1);

    // Short green
    snap = err_pulses;
    cyc(R, 1, 1, 31); cyc(G, 1, 1, 19); cyc(Y, 1, 1, 1);
    check("short_flags", 32'(err_flags), 32'h4);
    check("short_phase", 32'(phase), 3);
    check("short_pulses", 32'(err_pulses - snap), 1);

    // Red -> yellow order violation
    do_reset();
    cyc(R, 1, 1, 5); cyc(Y, 1, 1, 1);
    check("order_flags", 32'(err_flags), 32'h2);
    check("order_phase", 32'(phase), 0);
    check("order_locked", 32'(locked), 0);

    // Non-one-hot then relock
    do_reset();
    cyc(R, 1, 1, 3); cyc(R | G, 1, 1, 1);
    check("onehot_flags", 32'(err_flags), 32'h1);
    check("onehot_phase", 32'(phase), 0);
    cyc(R, 1, 1, 1);
    check("relock_locked", 32'(locked), 1);
    check("relock_flags", 32'(err_flags), 32'h1);

    // Enable gaps during green, then a change while disabled
    do_reset();
    cyc(R, 1, 1, 10); cyc(G, 1, 1, 10); cyc(G, 0, 1, 5);
    check("frozen_dwell", 32'(dwell), 10);
    cyc(G, 1, 1, 10); cyc(Y, 1, 1, 7);
    check("gap_flags", 32'(err_flags), 0);
    cyc(R, 0, 1, 1);
    check("stall_flags", 32'(err_flags), 32'h8);
    check("stall_error", 32'(error), 1);

    // Overstayed red
    do_reset();
    cyc(R, 1, 1, 3); cyc(G, 1, 1, 20); cyc(Y, 1, 1, 7);
    snap = err_pulses;
    cyc(R, 1, 1, 32);
    check("wd_before", 32'(err_pulses - snap), 0);
    cyc(R, 1, 1, 8);
`ifdef TRAFFIC_LIGHT_MON_WATCHDOG_EN
    check("wd_during", 32'(err_pulses - snap), 1);
`else
    check("wd_during", 32'(err_pulses - snap), 0);
`endif
    cyc(G, 1, 1, 1);
    check("wd_total", 32'(err_pulses - snap), 1);
    check("wd_flags", 32'(err_flags), 32'h4);

    // Random sequences, mostly legal with jittered lengths and enable gaps
    do_reset();
    cur = 1; left = 35;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom % 400;
      if (r == 0) begin
        do_reset();
        cur = 1; left = 35;
        continue;
      end
      en_r = ($urandom % 8) != 0;
      if (($urandom % 120) == 0) begin
        cyc(3'($urandom % 8), en_r, 1, 1);
        continue;
      end
      if (left <= 0) begin
        cur = (cur == 3) ? 1 : cur + 1;
        jit = $urandom_range(0, 3);
        left = plen(cur) + ((jit == 0) ? -1 : ((jit == 3) ? 1 : 0));
        // Mostly advance only on enabled edges so stalls stay occasional
        if (($urandom % 16) != 0) en_r = 1;
      end
      cyc(bits_of(cur), en_r, 1, 1);
      if (en_r) left--;
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
